dual_port_ram_byte_we: RTL and testbench

- True dual-port synchronous RAM, 32-bit words, per-byte write enables on each port.
- Serves as the storage array behind the On-Chip Memory (OCM) non-cacheable region, which holds flags, CSRs and atomic lock words.
- Port A is driven by the OCM arbiter's muxed core bus; port B is reserved for DMA or protocol controllers and is tied off (ena=0) when unused.
- Both ports run on a single clock.

---
 rtl/dual_port_ram_byte_we.sv | 70 +++++++
 tb/tb_dual_port_ram_byte_we.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_byte_we.sv
// dual_port_ram_byte_we
// True dual-port synchronous RAM, 32-bit words with per-byte write enables on
// both ports. Both ports share one clock. Reads are read-first with one cycle of
// latency. The array has no reset; only the output registers are cleared.
// If both ports write the same byte lane of the same word, port A's byte wins.

module dual_port_ram_byte_we #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,

  input  logic                  enaA,
  input  logic [3:0]            weA,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0] dinA,
  output logic [DATA_WIDTH-1:0] doutA,

  input  logic                  enaB,
  input  logic [3:0]            weB,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] dinB,
  output logic [DATA_WIDTH-1:0] doutB
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LANES = DATA_WIDTH / 8;

  // Storage starts out all zeros. It has no reset, so it can map to block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // Byte-lane writes for both ports. Writes are suppressed while reset is held.
  // Port B's writes are issued first, so port A's nonblocking assignment to the
  // same lane takes effect last and wins when the two collide.
  always_ff @(posedge clk) begin
    if (nrst) begin
      if (enaB) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (weB[i]) mem[addrB][8*i +: 8] <= dinB[8*i +: 8];
        end
      end
      if (enaA) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (weA[i]) mem[addrA][8*i +: 8] <= dinA[8*i +: 8];
        end
      end
    end
  end

  // Port A output register: reads the value from before this edge's writes.
  // The register holds its value while the port is disabled.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      doutA <= '0;
    end else if (enaA) begin
      doutA <= mem[addrA];
    end
  end

  // Port B output register: same read-first behaviour as port A.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      doutB <= '0;
    end else if (enaB) begin
      doutB <= mem[addrB];
    end
  end

endmodule

// File: tb/tb_dual_port_ram_byte_we.sv
// tb_dual_port_ram_byte_we
// Directed bench with a scoreboard. For every cycle it drives, it pushes the
// expected doutA and doutB values into queues, taken from a behavioural memory
// model. It pops and compares those values 1 time unit after the clock edge.
// Fixed expected values from the test plan are also checked directly.

module tb_dual_port_ram_byte_we;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          nrst;
  logic          enaA, enaB;
  logic [3:0]    weA, weB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dinA, dinB;
  logic [DW-1:0] doutA, doutB;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] qA [$];
  logic [DW-1:0] qB [$];
  logic [DW-1:0] lastA = '0;
  logic [DW-1:0] lastB = '0;

  dual_port_ram_byte_we #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .enaA (enaA),
    .weA  (weA),
    .addrA(addrA),
    .dinA (dinA),
    .doutA(doutA),
    .enaB (enaB),
    .weB  (weB),
    .addrB(addrB),
    .dinB (dinB),
    .doutB(doutB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict the outputs, then check them after the edge.
  task automatic step(input logic rn,
                      input logic ea, input logic [3:0] wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic eb, input logic [3:0] wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic [DW-1:0] ea_exp, eb_exp, ra, rb;
    nrst = rn;
    enaA = ea; weA = wa; addrA = aa; dinA = da;
    enaB = eb; weB = wb; addrB = ab; dinB = db;
    ra = model[aa];
    rb = model[ab];
    ea_exp = !rn ? '0 : (ea ? ra : lastA);
    eb_exp = !rn ? '0 : (eb ? rb : lastB);
    if (rn) begin
      for (int i = 0; i < 4; i++) begin
        if (eb && wb[i]) model[ab][8*i +: 8] = db[8*i +: 8];
      end
      for (int i = 0; i < 4; i++) begin
        if (ea && wa[i]) model[aa][8*i +: 8] = da[8*i +: 8];
      end
    end
    lastA = ea_exp;
    lastB = eb_exp;
    qA.push_back(ea_exp);
    qB.push_back(eb_exp);
    @(posedge clk);
    #1;
    if (qA.size() == 0) chk("qA_empty", 32'h1, 32'h0);
    else chk("doutA", doutA, qA.pop_front());
    if (qB.size() == 0) chk("qB_empty", 32'h1, 32'h0);
    else chk("doutB", doutB, qB.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
    nrst = 1'b0;
    enaA = 1'b0; weA = '0; addrA = '0; dinA = '0;
    enaB = 1'b0; weB = '0; addrB = '0; dinB = '0;
    @(negedge clk);

    // Reset for two cycles with port A enabled and attempting a write.
    step(1'b0, 1'b1, 4'hF, 12'd0, 32'h5555_5555, 1'b1, 4'hF, 12'd1, 32'h6666_6666);
    chk("reset_doutA", doutA, 32'h0);
    step(1'b0, 1'b1, 4'hF, 12'd0, 32'h5555_5555, 1'b1, 4'hF, 12'd1, 32'h6666_6666);
    chk("reset_doutB", doutB, 32'h0);
    step(1'b1, 1'b1, 4'h0, 12'd0, 32'h0, 1'b1, 4'h0, 12'd1, 32'h0);
    chk("reset_nowriteA", doutA, 32'h0);
    chk("reset_nowriteB", doutB, 32'h0);

    // Full-word write, then read it back.
    step(1'b1, 1'b1, 4'hF, 12'd5, 32'hDEAD_BEEF, 1'b0, 4'h0, 12'd0, 32'h0);
    step(1'b1, 1'b1, 4'h0, 12'd5, 32'h0, 1'b0, 4'h0, 12'd0, 32'h0);
    chk("full_word", doutA, 32'hDEAD_BEEF);

    // Enable hold: a disabled port neither reads nor writes.
    step(1'b1, 1'b0, 4'hF, 12'd10, 32'h1234_5678, 1'b0, 4'hF, 12'd11, 32'h8765_4321);
    chk("hold_doutA", doutA, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 4'h0, 12'd10, 32'h0, 1'b1, 4'h0, 12'd11, 32'h0);
    chk("hold_nowriteA", doutA, 32'h0);
    chk("hold_nowriteB", doutB, 32'h0);

    // Byte-masked write.
    step(1'b1, 1'b1, 4'hF, 12'd7, 32'h1122_3344, 1'b0, 4'h0, 12'd0, 32'h0);
    step(1'b1, 1'b1, 4'b0101, 12'd7, 32'hAABB_CCDD, 1'b0, 4'h0, 12'd0, 32'h0);
    step(1'b1, 1'b1, 4'h0, 12'd7, 32'h0, 1'b0, 4'h0, 12'd0, 32'h0);
    chk("byte_mask", doutA, 32'h11BB_33DD);

    // Read-first on the same port.
    step(1'b1, 1'b1, 4'hF, 12'd9, 32'h1, 1'b0, 4'h0, 12'd0, 32'h0);
    step(1'b1, 1'b1, 4'hF, 12'd9, 32'h2, 1'b0, 4'h0, 12'd0, 32'h0);
    chk("read_first_old", doutA, 32'h1);
    step(1'b1, 1'b1, 4'h0, 12'd9, 32'h0, 1'b0, 4'h0, 12'd0, 32'h0);
    chk("read_first_new", doutA, 32'h2);

    // Cross-port: A writes, then B reads the same address.
    step(1'b1, 1'b1, 4'hF, 12'd3, 32'hCAFE_F00D, 1'b1, 4'h0, 12'd3, 32'h0);
    chk("cross_old", doutB, 32'h0);
    step(1'b1, 1'b0, 4'h0, 12'd0, 32'h0, 1'b1, 4'h0, 12'd3, 32'h0);
    chk("cross_new", doutB, 32'hCAFE_F00D);

    // B writes while A reads the same address.
    step(1'b1, 1'b1, 4'h0, 12'd3, 32'h0, 1'b1, 4'b1100, 12'd3, 32'h7777_0000);
    chk("b_write_a_old", doutA, 32'hCAFE_F00D);
    step(1'b1, 1'b1, 4'h0, 12'd3, 32'h0, 1'b0, 4'h0, 12'd0, 32'h0);
    chk("b_write_a_new", doutA, 32'h7777_F00D);
    chk("b_hold", doutB, 32'hCAFE_F00D);

    // Collision: both ports write addr 4, and port A wins every lane it writes.
    step(1'b1, 1'b1, 4'hF, 12'd4, 32'h0000_00AA, 1'b1, 4'h3, 12'd4, 32'h0000_BBBB);
    step(1'b1, 1'b1, 4'h0, 12'd4, 32'h0, 1'b1, 4'h0, 12'd4, 32'h0);
    chk("collide_A", doutA, 32'h0000_00AA);
    chk("collide_B", doutB, 32'h0000_00AA);

    // Partial collision: a lane written only by B keeps B's byte.
    step(1'b1, 1'b1, 4'b0001, 12'd6, 32'h0000_0011, 1'b1, 4'b0011, 12'd6, 32'h0000_2222);
    step(1'b1, 1'b0, 4'h0, 12'd0, 32'h0, 1'b1, 4'h0, 12'd6, 32'h0);
    chk("collide_lanes", doutB, 32'h0000_2211);

    // Independent accesses at the top and bottom addresses.
    step(1'b1, 1'b1, 4'hF, 12'hFFF, 32'hA5A5_5A5A, 1'b1, 4'hF, 12'h000, 32'h0F0F_F0F0);
    step(1'b1, 1'b1, 4'h0, 12'h000, 32'h0, 1'b1, 4'h0, 12'hFFF, 32'h0);
    chk("top_addr", doutB, 32'hA5A5_5A5A);
    chk("bottom_addr", doutA, 32'h0F0F_F0F0);

    // A mid-run reset clears both outputs but leaves the array contents intact.
    step(1'b0, 1'b1, 4'hF, 12'd5, 32'h0, 1'b1, 4'hF, 12'd7, 32'h0);
    chk("rst2_doutA", doutA, 32'h0);
    step(1'b1, 1'b1, 4'h0, 12'd5, 32'h0, 1'b1, 4'h0, 12'd7, 32'h0);
    chk("rst2_keepA", doutA, 32'hDEAD_BEEF);
    chk("rst2_keepB", doutB, 32'h11BB_33DD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
